// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 set-2 scan-code prefix decoder feeding a first-word-fall-through event FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_done_tick,
  input  logic [7:0]                      rx_data,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [7:0]                      ev_code,
  output logic                            ev_extended,
  output logic                            ev_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
  output logic                            overflow,
  output logic                            seq_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic emit, e_ext, e_brk, err, seq_err_q;
  logic [7:0] e_code;
  logic b_e0, b_f0, b_e1, ctrl;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic overflow_q, full, pop, push_ok;
  assign b_e0 = rx_data == 8'hE0;
  assign b_f0 = rx_data == 8'hF0;
  assign b_e1 = rx_data == 8'hE1;
  assign ctrl = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    e_code  = rx_data;
    e_ext   = 1'b0;
    e_brk   = 1'b0;
    err     = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE:
          if (b_e0) state_d = EXT;
          else if (b_f0) state_d = BRK;
          else if (b_e1) begin
            state_d = PAUSE;
            skip_d  = 3'd0;
          end else emit = !ctrl;
        EXT:
          if (b_f0) state_d = EXT_BRK;
          else if (!b_e0) begin
            state_d = IDLE;
            err     = b_e1;
            emit    = !b_e1 && !ctrl;
            e_ext   = 1'b1;
          end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          err     = b_e0 || b_f0 || b_e1 || ctrl;
          emit    = !err;
          e_brk   = 1'b1;
          e_ext   = state_q == EXT_BRK;
        end
        PAUSE:
          // Pause bytes are counted blindly; the 7th one closes the sequence
          if (skip_q == 3'd6) begin
            emit    = 1'b1;
            e_code  = 8'h77;
            e_ext   = 1'b1;
            state_d = IDLE;
            skip_d  = 3'd0;
          end else skip_d = skip_q + 3'd1;
        default: state_d = IDLE;
      endcase
    end
  end
  assign full     = count_q == CW'(FIFO_DEPTH);
  assign ev_valid = count_q != '0;
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = emit && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      skip_q     <= 3'd0;
      seq_err_q  <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      seq_err_q  <= err;
      wr_q       <= wr_q + AW'(push_ok);
      rd_q       <= rd_q + AW'(pop);
      count_q    <= count_q + CW'(push_ok) - CW'(pop);
      overflow_q <= overflow_q || (emit && !push_ok);
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= {e_ext, e_brk, e_code};
  assign ev_code     = ev_valid ? mem_q[rd_q][7:0] : 8'h00;
  assign ev_break    = ev_valid && mem_q[rd_q][8];
  assign ev_extended = ev_valid && mem_q[rd_q][9];
  assign ev_count    = count_q;
  assign overflow    = overflow_q;
  assign seq_err     = seq_err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scan-code vectors with a queue scoreboard checked by a handshake monitor
module tb_ps2_scancode_decoder;
  logic clk = 0, rst = 1, rx_done_tick = 0, ev_ready = 0;
  logic [7:0] rx_data = 8'h00;
  logic ev_valid, ev_extended, ev_break, overflow, seq_err;
  logic [7:0] ev_code;
  logic [2:0] ev_count;
  int n_cmp = 0, n_bad = 0, err_seen = 0;
  logic [9:0] exp_q [$];

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_extended(ev_extended), .ev_break(ev_break), .ev_count(ev_count),
    .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1; rx_data = b;
    @(posedge clk); #1;
    rx_done_tick = 0;
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic drain();
    int k = 0;
    ev_ready = 1;
    while ((exp_q.size() != 0 || ev_valid) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && seq_err) err_seen++;
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event", {ev_extended, ev_break, ev_code}, 10'h3ff);
      else chk("event", {ev_extended, ev_break, ev_code}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", seq_err, 0);
    rst = 0;
    ev_ready = 1;
    // make then break of the same key, each visible one cycle after its last byte
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    chk("lat_make", ev_valid, 1);
    send(8'hF0);
    chk("no_ev_prefix", ev_valid, 0);
    expect_ev(8'h1C, 0, 1);
    send(8'h1C);
    chk("lat_break", ev_valid, 1);
    drain();
    // extended make/break
    e0 = err_seen;
    send(8'hE0);
    expect_ev(8'h75, 1, 0);
    send(8'h75);
    send(8'hE0); send(8'hF0);
    expect_ev(8'h75, 1, 1);
    send(8'h75);
    drain();
    chk("ext_no_err", err_seen - e0, 0);
    // Pause: eight bytes, one event on the last
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_pending", ev_valid, 0);
    expect_ev(8'h77, 1, 0);
    send(8'h77);
    chk("pause_lat", ev_valid, 1);
    drain();
    // overflow with consumer stalled
    ev_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_ev(8'h15 + 8'(i), 0, 0);
      send(8'h15 + 8'(i));
    end
    chk("full_count", ev_count, 4);
    chk("ovf_set", overflow, 1);
    // push and pop together while full
    expect_ev(8'h1B, 0, 0);
    @(posedge clk); #1;
    ev_ready = 1; rx_done_tick = 1; rx_data = 8'h1B;
    @(posedge clk); #1;
    rx_done_tick = 0; ev_ready = 0;
    chk("full_pushpop_count", ev_count, 4);
    chk("ovf_sticky", overflow, 1);
    drain();
    chk("empty_code", ev_code, 0);
    // malformed prefix then recovery
    e0 = err_seen;
    send(8'hF0);
    send(8'hE0);
    chk("err_pulse", seq_err, 1);
    @(posedge clk); #1;
    chk("err_one_cycle", seq_err, 0);
    chk("err_count", err_seen - e0, 1);
    chk("err_no_ev", ev_valid, 0);
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    send(8'hAA);
    send(8'hFA);
    drain();
    chk("ctrl_no_ev", ev_valid, 0);
    // reset abandons a pending E0 prefix
    send(8'hE0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst2_valid", ev_valid, 0);
    chk("rst2_count", ev_count, 0);
    chk("rst2_ovf", overflow, 0);
    chk("rst2_code", ev_code, 0);
    chk("rst2_ext", ev_extended, 0);
    rst = 0;
    expect_ev(8'h75, 0, 0);
    send(8'h75);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver: rx_data holds a new byte.
REQ-005 SHALL have port rx_data  input  8  received scan-code byte, valid only with rx_done_tick.
REQ-006 SHALL have port ev_valid  output  1  FIFO head holds a key event.
REQ-007 SHALL have port ev_ready  input  1  consumer accepts the head event this cycle.
REQ-008 SHALL have port ev_code  output  8  head event scan code.
REQ-009 SHALL have port ev_extended  output  1  head event was E0-prefixed, or is Pause.
REQ-010 SHALL have port ev_break  output  1  head event is a release (F0-prefixed).
REQ-011 SHALL have port ev_count  output  clog2(FIFO_DEPTH+1)  events currently buffered.
REQ-012 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 SHALL have port seq_err  output  1  one-cycle pulse on a malformed prefix sequence.

Function
REQ-014 SHALL decode PS/2 scan-code set 2 with FSM states IDLE, EXT, BRK, EXT_BRK, PAUSE; the FSM advances only on cycles with rx_done_tick=1.
REQ-015 SHALL treat 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF as control bytes: discarded in every state, no event emitted.
REQ-016 IDLE: 0xE0->EXT; 0xF0->BRK; 0xE1->PAUSE (skip counter cleared to 0); control byte->IDLE; any other byte->emit {code=byte, ext=0, brk=0}, stay IDLE.
REQ-017 EXT: 0xF0->EXT_BRK; 0xE0->EXT (repeat ignored); control byte->IDLE; 0xE1->seq_err, IDLE; other->emit {byte, ext=1, brk=0}, IDLE.
REQ-018 BRK: 0xE0, 0xF0, 0xE1 or control byte->seq_err pulse, byte discarded, IDLE; other->emit {byte, ext=0, brk=1}, IDLE.
REQ-019 EXT_BRK: 0xE0, 0xF0, 0xE1 or control byte->seq_err pulse, byte discarded, IDLE; other->emit {byte, ext=1, brk=1}, IDLE.
REQ-020 PAUSE: 3-bit skip counter counts each received byte without inspecting its value; on the 7th byte after 0xE1, emit {code=0x77, ext=1, brk=0} and go to IDLE.
REQ-021 seq_err SHALL assert in the cycle after the offending rx_done_tick, for exactly one cycle.
REQ-022 An emit SHALL push one entry into the FIFO on the rx_done_tick cycle; if the FIFO was empty, ev_valid rises the next cycle (latency 1).
REQ-023 FIFO SHALL be first-word-fall-through: ev_code/ev_extended/ev_break reflect the head whenever ev_valid=1; outputs are 0 when empty.
REQ-024 Pop SHALL occur on a cycle with ev_valid=1 and ev_ready=1; ev_ready while empty has no effect.
REQ-025 Push and pop in the same cycle SHALL both take effect, leaving ev_count unchanged, including when full.
REQ-026 A push when full with no simultaneous pop SHALL drop the new event, leave the FIFO unchanged, and set overflow, which stays 1 until rst.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; ev_count SHALL range 0..FIFO_DEPTH.
REQ-028 Event order at the output SHALL equal emit order.

Reset
REQ-029 While rst=1: FSM->IDLE, skip counter=0, FIFO emptied, ev_count=0, ev_valid=0, ev_code=0, ev_extended=0, ev_break=0, overflow=0, seq_err=0; rx_done_tick ignored.
REQ-030 Reset mid-sequence (e.g. after 0xE0 or inside PAUSE) SHALL abandon the partial sequence; no event emitted for it after reset.

Verification
REQ-031 Bytes 1C, F0 1C with ev_ready=1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; ev_valid one cycle after each final tick.
REQ-032 Bytes E0 75, E0 F0 75 -> {75,ext1,brk0}, {75,ext1,brk1}; seq_err never asserts.
REQ-033 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,ext1,brk0}, emitted on the 8th byte.
REQ-034 FIFO_DEPTH=4, ev_ready=0, six make codes 15..1A -> ev_count=4, overflow=1, popping yields 15,16,17,18; push with simultaneous pop when full -> count stays 4, overflow unchanged.
REQ-035 Bytes F0 E0 -> seq_err one-cycle pulse, no event; next byte 1C -> {1C,ext0,brk0}; AA and FA in IDLE -> no event.
REQ-036 Bytes E0 then rst for one cycle then 75 -> {75,ext0,brk0}; all outputs 0 during reset.
